// File: rtl/rv_wb_arbiter.sv
// Register-file write-port arbiter: fixed priority for the pipeline, round-robin for
// long-latency units, starvation hold, and a busy scoreboard for decode hazards.
module rv_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*5-1:0]      i_req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic                      i_alloc,
    input  logic [4:0]                i_alloc_rd,
    input  logic [4:0]                i_rs1,
    input  logic [4:0]                i_rs2,
    output logic                      o_rs1_busy,
    output logic                      o_rs2_busy,
    output logic [31:0]               o_busy_map,
    output logic [4:0]                o_rd,
    output logic                      o_write,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_pipe_hold
);
    localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0]   ASYNC_CNT = (IDX_W+1)'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
    localparam logic [3:0]       LIM       = 4'(STARVE_LIM);

    logic [NUM_REQ-1:0] grant_s;
    logic               found_s;
    logic               hit_s;
    logic [IDX_W:0]     sum_s;
    logic [IDX_W-1:0]   idx_s;
    logic [IDX_W-1:0]   ptr_or_s;
    logic [IDX_W-1:0]   rr_next_s;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [4:0]         win_rd_s;
    logic [DATA_W-1:0]  win_data_s;
    logic               any_grant_s;
    logic               async_grant_s;
    logic               async_valid_s;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_next_s;
    logic               hold_r;
    logic               hold_next_s;
    logic [31:0]        busy_r;
    logic [31:0]        busy_next_s;
    logic [31:0]        clr_mask_s;
    logic [31:0]        set_mask_s;
    logic               write_r;
    logic [4:0]         rd_r;
    logic [DATA_W-1:0]  data_r;

    // Grant selection: pipeline first unless held, else round-robin over async units
    always_comb begin
        grant_s = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        if (!hold_r && i_req_valid[0]) begin
            grant_s[0] = 1'b1;
        end else begin
            for (int i = 0; i < NUM_REQ - 1; i++) begin
                sum_s   = {1'b0, rr_ptr_r} + (IDX_W+1)'(i);
                sum_s   = (sum_s > ASYNC_CNT) ? (sum_s - ASYNC_CNT) : sum_s;
                idx_s   = sum_s[IDX_W-1:0];
                hit_s   = !found_s && i_req_valid[idx_s];
                grant_s[idx_s] = grant_s[idx_s] | hit_s;
                found_s = found_s | hit_s;
            end
        end
    end

    // One-hot winner mux and next round-robin pointer
    always_comb begin
        win_rd_s   = '0;
        win_data_s = '0;
        ptr_or_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            win_rd_s   = win_rd_s   | (i_req_rd[k*5 +: 5] & {5{grant_s[k]}});
            win_data_s = win_data_s | (i_req_data[k*DATA_W +: DATA_W] & {DATA_W{grant_s[k]}});
            if (k >= 1) begin
                ptr_or_s = ptr_or_s | ({IDX_W{grant_s[k]}} &
                           ((k == NUM_REQ - 1) ? FIRST_IDX : IDX_W'(k + 1)));
            end else begin
                ptr_or_s = ptr_or_s;
            end
        end
    end

    assign any_grant_s   = |grant_s;
    assign async_grant_s = |grant_s[NUM_REQ-1:1];
    assign async_valid_s = |i_req_valid[NUM_REQ-1:1];
    assign rr_next_s     = async_grant_s ? ptr_or_s : rr_ptr_r;

    // Starvation counter (saturating) and pipeline-hold decision
    always_comb begin
        if (async_grant_s || !async_valid_s) begin
            cnt_next_s  = 4'd0;
            hold_next_s = 1'b0;
        end else begin
            cnt_next_s  = (cnt_r != 4'hF) ? (cnt_r + 4'd1) : cnt_r;
            hold_next_s = (cnt_next_s >= LIM) ? 1'b1 : hold_r;
        end
    end

    // Scoreboard update: a same-edge allocation of the register being written wins
    always_comb begin
        clr_mask_s  = write_r ? (32'd1 << rd_r) : 32'd0;
        set_mask_s  = (i_alloc && (i_alloc_rd != 5'd0)) ? (32'd1 << i_alloc_rd) : 32'd0;
        busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
    end

    // All arbiter state; reset drops any registered-but-unwritten grant
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            write_r  <= 1'b0;
            rd_r     <= 5'd0;
            data_r   <= '0;
            hold_r   <= 1'b0;
            cnt_r    <= 4'd0;
            busy_r   <= 32'd0;
            rr_ptr_r <= FIRST_IDX;
        end else begin
            write_r  <= any_grant_s && (win_rd_s != 5'd0);
            rd_r     <= any_grant_s ? win_rd_s : rd_r;
            data_r   <= any_grant_s ? win_data_s : data_r;
            hold_r   <= hold_next_s;
            cnt_r    <= cnt_next_s;
            busy_r   <= busy_next_s;
            rr_ptr_r <= rr_next_s;
        end
    end

    assign o_req_ready = grant_s;
    assign o_write     = write_r;
    assign o_rd        = rd_r;
    assign o_data      = data_r;
    assign o_pipe_hold = hold_r;
    assign o_busy_map  = busy_r;
    assign o_rs1_busy  = busy_r[i_rs1];
    assign o_rs2_busy  = busy_r[i_rs2];

    rv_wb_arbiter_chk #(.NUM_REQ(NUM_REQ)) u_chk (
        .clk      (i_clk),
        .rst      (i_reset),
        .ready    (grant_s),
        .valid    (i_req_valid),
        .alloc    (i_alloc),
        .alloc_rd (i_alloc_rd),
        .busy     (busy_r),
        .write    (write_r),
        .rd       (rd_r)
    );
endmodule

// Simulation checks: one-hot grant, no grant without request, no re-allocation of a
// register still outstanding (re-allocating in its clearing cycle is legal).
module rv_wb_arbiter_chk #(
    parameter int NUM_REQ = 3
) (
    input logic               clk,
    input logic               rst,
    input logic [NUM_REQ-1:0] ready,
    input logic [NUM_REQ-1:0] valid,
    input logic               alloc,
    input logic [4:0]         alloc_rd,
    input logic [31:0]        busy,
    input logic               write,
    input logic [4:0]         rd
);
    // Per-edge protocol checks while out of reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(ready)) else $error("arbiter grant not one-hot");
            assert ((ready & ~valid) == '0) else $error("arbiter grant without request");
            assert (!(alloc && (alloc_rd != 5'd0) && busy[alloc_rd] &&
                      !(write && (rd == alloc_rd))))
                else $error("alloc to busy register %0d", alloc_rd);
        end
    end
endmodule
